// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared depth constant and pointer wrap helper for the read drain
package fifo_rd_stream_pkg;
  localparam int DEPTH = 3;
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 3-entry circular register buffer that absorbs RAM read latency
module fifo_rd_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd,
  input  logic                  flush,
  output logic [1:0]            cnt,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] last;
  logic [1:0]            head, tail;
  // head entry is shown while occupied; otherwise the last shown word is held
  always_comb begin
    valid = cnt != 2'd0;
    rdata = valid ? mem[head] : last;
  end
  // storage needs no reset: it is only visible through cnt-qualified reads
  always_ff @(posedge clk) begin
    if (wr) mem[tail] <= wdata;
  end
  // occupancy and pointers; flush empties the buffer in one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      head <= '0;
      tail <= '0;
      last <= '0;
    end else begin
      last <= rdata;
      if (flush) begin
        cnt  <= '0;
        head <= '0;
        tail <= '0;
      end else begin
        if (wr) tail <= ptr_inc(tail);
        if (rd) head <= ptr_inc(head);
        cnt <= cnt + {1'b0, wr} - {1'b0, rd};
      end
    end
  end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops the dual-clock FIFO and presents its words as a valid/ready stream
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  r_clk,
  input  logic                  rst_n,
  input  logic                  r_empty,
  output logic                  r_pop,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);
  logic [1:0] cnt;
  logic       inflight, acc;
  fifo_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (r_clk),
    .rst_n (rst_n),
    .wr    (inflight && !flush),
    .wdata (r_data),
    .rd    (acc),
    .flush (flush),
    .cnt   (cnt),
    .valid (m_valid),
    .rdata (m_data)
  );
  // pop only when a slot is guaranteed for the returning word; m_ready is deliberately excluded
  always_comb begin
    acc   = m_valid && m_ready;
    r_pop = rst_n && !r_empty && !flush && (({1'b0, cnt} + {2'b0, inflight}) < 3'(DEPTH));
  end
  // track the word in flight from the registered RAM read and count accepted beats
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      inflight <= r_pop;
      beat_cnt <= beat_cnt + CNT_WIDTH'(acc);
    end
  end
endmodule
